// File: rtl/interrupt_controller.sv
// Prioritised interrupt controller: arbitrates peripheral raise lines, presents one request to
// the CPU, returns a one-cycle acknowledge to the serviced source, and exposes a small register window.
module interrupt_controller #(
  parameter int unsigned NumSources = 2,
  parameter logic [7:0]  BaseAddr   = 8'hF8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  inout  wire  [7:0]            BUS_DATA,
  input  logic [7:0]            BUS_ADDR,
  input  logic                  BUS_WE,
  input  logic [NumSources-1:0] IRQ_RAISE,
  output logic [NumSources-1:0] IRQ_ACK,
  output logic                  CPU_INTERRUPT,
  output logic [2:0]            CPU_INTERRUPT_ID,
  input  logic                  CPU_INTERRUPT_ACK
);

  typedef enum logic [1:0] {StIdle, StRequest, StAck, StSettle} state_e;

  state_e                  state_q, state_d;
  logic                    cpu_int_q, cpu_int_d;
  logic [2:0]              id_q, id_d;
  logic [NumSources-1:0]   irq_ack_q, irq_ack_d;
  logic [NumSources-1:0]   mask_q, mask_d;
  logic                    rd_sel_q, rd_sel_d;
  logic [1:0]              rd_off_q, rd_off_d;

  logic [7:0]              addr_off;
  logic                    in_window;
  logic [NumSources-1:0]   pending;
  logic [2:0]              win_id;
  logic                    found;
  logic [7:0]              rd_data;

  // Bus decode
  assign addr_off  = BUS_ADDR - BaseAddr;
  assign in_window = (addr_off < 8'd3);

  always_comb begin
    mask_d = mask_q;
    if (BUS_WE && (addr_off == 8'd1)) begin
      mask_d = BUS_DATA[NumSources-1:0];
    end
  end

  always_comb begin
    rd_sel_d = in_window && !BUS_WE;
    rd_off_d = addr_off[1:0];
  end

  // Read data uses live state, so +0 reflects IRQ_RAISE during the drive cycle.
  always_comb begin
    rd_data = '0;
    case (rd_off_q)
      2'd0: begin
        rd_data[NumSources-1:0] = IRQ_RAISE;
        rd_data[7]              = (state_q != StIdle);
      end
      2'd1:    rd_data[NumSources-1:0] = mask_q;
      2'd2:    rd_data[2:0]            = id_q;
      default: rd_data                 = '0;
    endcase
  end

  assign BUS_DATA = rd_sel_q ? rd_data : 8'hZZ;

  // Fixed priority: lowest enabled index wins.
  assign pending = IRQ_RAISE & mask_q;

  always_comb begin
    win_id = '0;
    found  = 1'b0;
    for (int i = NumSources - 1; i >= 0; i--) begin
      if (pending[i]) begin
        win_id = 3'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cpu_int_d = cpu_int_q;
    id_d      = id_q;
    irq_ack_d = '0;
    case (state_q)
      StIdle: begin
        if (found) begin
          id_d      = win_id;
          cpu_int_d = 1'b1;
          state_d   = StRequest;
        end
      end
      StRequest: begin
        // The request is latched: dropping the raise or mask does not cancel it.
        if (CPU_INTERRUPT_ACK) begin
          cpu_int_d = 1'b0;
          irq_ack_d = NumSources'(1) << id_q;
          state_d   = StAck;
        end
      end
      StAck:    state_d = StSettle;
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      cpu_int_q <= 1'b0;
      id_q      <= '0;
      irq_ack_q <= '0;
      mask_q    <= '1;
      rd_sel_q  <= 1'b0;
      rd_off_q  <= '0;
    end else begin
      state_q   <= state_d;
      cpu_int_q <= cpu_int_d;
      id_q      <= id_d;
      irq_ack_q <= irq_ack_d;
      mask_q    <= mask_d;
      rd_sel_q  <= rd_sel_d;
      rd_off_q  <= rd_off_d;
    end
  end

  assign IRQ_ACK          = irq_ack_q;
  assign CPU_INTERRUPT    = cpu_int_q;
  assign CPU_INTERRUPT_ID = id_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller (NumSources=2, BaseAddr=8'hF8).
module tb_interrupt_controller;

  localparam logic [7:0] Base = 8'hF8;

  logic       clk;
  logic       rst_n;
  wire  [7:0] bus_data;
  logic [7:0] tb_drv;
  logic       tb_oe;
  logic [7:0] bus_addr;
  logic       bus_we;
  logic [1:0] irq_raise;
  logic [1:0] irq_ack;
  logic       cpu_int;
  logic [2:0] cpu_id;
  logic       cpu_ack;

  int errors = 0;
  int checks = 0;

  assign bus_data = tb_oe ? tb_drv : 8'hzz;

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (bus_data[g]);
  end

  interrupt_controller #(
    .NumSources(2),
    .BaseAddr  (Base)
  ) dut (
    .CLK              (clk),
    .RESET_N          (rst_n),
    .BUS_DATA         (bus_data),
    .BUS_ADDR         (bus_addr),
    .BUS_WE           (bus_we),
    .IRQ_RAISE        (irq_raise),
    .IRQ_ACK          (irq_ack),
    .CPU_INTERRUPT    (cpu_int),
    .CPU_INTERRUPT_ID (cpu_id),
    .CPU_INTERRUPT_ACK(cpu_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [7:0] val);
    bus_addr = Base + {6'd0, off};
    bus_we   = 1'b0;
    tick();
    val      = bus_data;
    bus_addr = 8'h00;
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [7:0] val);
    bus_addr = Base + {6'd0, off};
    bus_we   = 1'b1;
    tb_drv   = val;
    tb_oe    = 1'b1;
    tick();
    tb_oe    = 1'b0;
    bus_we   = 1'b0;
    bus_addr = 8'h00;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst_n = 1'b0;
    #1;
    checks++;
    if (cpu_int !== 1'b0 || irq_ack !== 2'b00 || cpu_id !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: int=%b ack=%b id=%0d, want 0 00 0", cpu_int, irq_ack, cpu_id);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    bus_read(2'd1, v);
    checks++;
    if (v !== 8'h03) begin
      errors++;
      $display("FAIL reset_mask: got %h want 03", v);
    end
    tick();
    checks++;
    if (bus_data !== 8'hff) begin
      errors++;
      $display("FAIL bus_idle_z: got %h want ff (released)", bus_data);
    end
    bus_read(2'd0, v);
    checks++;
    if (v !== 8'h00) begin
      errors++;
      $display("FAIL reset_status: got %h want 00", v);
    end
    bus_read(2'd2, v);
    checks++;
    if (v !== 8'h00) begin
      errors++;
      $display("FAIL reset_id: got %h want 00", v);
    end
    tick();
  endtask

  task automatic test_ack_ignored();
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    checks++;
    if (irq_ack !== 2'b00 || cpu_int !== 1'b0) begin
      errors++;
      $display("FAIL ack_in_idle: ack=%b int=%b want 00 0", irq_ack, cpu_int);
    end
  endtask

  task automatic test_single();
    logic [7:0] v;
    irq_raise = 2'b10;
    tick();
    checks++;
    if (cpu_int !== 1'b1 || cpu_id !== 3'd1) begin
      errors++;
      $display("FAIL single_req: int=%b id=%0d want 1 1", cpu_int, cpu_id);
    end
    bus_read(2'd0, v);
    checks++;
    if (v !== 8'h82) begin
      errors++;
      $display("FAIL single_status: got %h want 82", v);
    end
    bus_read(2'd2, v);
    checks++;
    if (v !== 8'h01) begin
      errors++;
      $display("FAIL single_id_reg: got %h want 01", v);
    end
    cpu_ack = 1'b1;
    tick();
    cpu_ack   = 1'b0;
    irq_raise = 2'b00;
    checks++;
    if (cpu_int !== 1'b0 || irq_ack !== 2'b10) begin
      errors++;
      $display("FAIL single_ack: int=%b ack=%b want 0 10", cpu_int, irq_ack);
    end
    tick();
    checks++;
    if (irq_ack !== 2'b00) begin
      errors++;
      $display("FAIL single_ack_width: ack=%b want 00", irq_ack);
    end
    tick();
    tick();
    tick();
    checks++;
    if (cpu_int !== 1'b0 || cpu_id !== 3'd1) begin
      errors++;
      $display("FAIL single_no_rereq: int=%b id=%0d want 0 1", cpu_int, cpu_id);
    end
  endtask

  task automatic test_priority();
    irq_raise = 2'b11;
    tick();
    checks++;
    if (cpu_int !== 1'b1 || cpu_id !== 3'd0) begin
      errors++;
      $display("FAIL prio_first: int=%b id=%0d want 1 0", cpu_int, cpu_id);
    end
    cpu_ack = 1'b1;
    tick();
    cpu_ack   = 1'b0;
    irq_raise = 2'b10;
    checks++;
    if (irq_ack !== 2'b01) begin
      errors++;
      $display("FAIL prio_ack0: ack=%b want 01", irq_ack);
    end
    tick();
    tick();
    checks++;
    if (cpu_int !== 1'b0) begin
      errors++;
      $display("FAIL prio_settle: int=%b want 0 at m+2", cpu_int);
    end
    tick();
    checks++;
    if (cpu_int !== 1'b1 || cpu_id !== 3'd1) begin
      errors++;
      $display("FAIL prio_second: int=%b id=%0d want 1 1 at m+3", cpu_int, cpu_id);
    end
    cpu_ack = 1'b1;
    tick();
    cpu_ack   = 1'b0;
    irq_raise = 2'b00;
    checks++;
    if (irq_ack !== 2'b10) begin
      errors++;
      $display("FAIL prio_ack1: ack=%b want 10", irq_ack);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_mask();
    logic [7:0] v;
    bus_write(2'd1, 8'h01);
    bus_read(2'd1, v);
    checks++;
    if (v !== 8'h01) begin
      errors++;
      $display("FAIL mask_readback: got %h want 01", v);
    end
    irq_raise = 2'b10;
    tick();
    tick();
    checks++;
    if (cpu_int !== 1'b0) begin
      errors++;
      $display("FAIL mask_blocks: int=%b want 0", cpu_int);
    end
    bus_read(2'd0, v);
    checks++;
    if (v !== 8'h02) begin
      errors++;
      $display("FAIL mask_status: got %h want 02", v);
    end
    bus_write(2'd1, 8'h03);
    checks++;
    if (cpu_int !== 1'b0) begin
      errors++;
      $display("FAIL mask_old_used: int=%b want 0 at write edge", cpu_int);
    end
    tick();
    checks++;
    if (cpu_int !== 1'b1 || cpu_id !== 3'd1) begin
      errors++;
      $display("FAIL mask_enable: int=%b id=%0d want 1 1", cpu_int, cpu_id);
    end
    cpu_ack = 1'b1;
    tick();
    cpu_ack   = 1'b0;
    irq_raise = 2'b00;
    tick();
    tick();
    tick();
  endtask

  task automatic test_latched();
    irq_raise = 2'b01;
    tick();
    irq_raise = 2'b00;
    tick();
    tick();
    checks++;
    if (cpu_int !== 1'b1 || cpu_id !== 3'd0) begin
      errors++;
      $display("FAIL latched_hold: int=%b id=%0d want 1 0", cpu_int, cpu_id);
    end
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    checks++;
    if (irq_ack !== 2'b01 || cpu_int !== 1'b0) begin
      errors++;
      $display("FAIL latched_ack: ack=%b int=%b want 01 0", irq_ack, cpu_int);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    irq_raise = 2'b01;
    tick();
    checks++;
    if (cpu_int !== 1'b1) begin
      errors++;
      $display("FAIL midrst_req: int=%b want 1", cpu_int);
    end
    cpu_ack = 1'b1;
    rst_n   = 1'b0;
    #1;
    checks++;
    if (cpu_int !== 1'b0 || irq_ack !== 2'b00) begin
      errors++;
      $display("FAIL midrst_async: int=%b ack=%b want 0 00", cpu_int, irq_ack);
    end
    tick();
    cpu_ack = 1'b0;
    checks++;
    if (irq_ack !== 2'b00) begin
      errors++;
      $display("FAIL midrst_no_ack: ack=%b want 00", irq_ack);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (cpu_int !== 1'b1 || cpu_id !== 3'd0 || irq_ack !== 2'b00) begin
      errors++;
      $display("FAIL midrst_rereq: int=%b id=%0d ack=%b want 1 0 00", cpu_int, cpu_id, irq_ack);
    end
    irq_raise = 2'b00;
    bus_read(2'd0, v);
    checks++;
    if (v !== 8'h80) begin
      errors++;
      $display("FAIL midrst_busy: got %h want 80", v);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    tb_drv    = 8'h00;
    tb_oe     = 1'b0;
    bus_addr  = 8'h00;
    bus_we    = 1'b0;
    irq_raise = 2'b00;
    cpu_ack   = 1'b0;
    test_reset();
    test_ack_ignored();
    test_single();
    test_priority();
    test_mask();
    test_latched();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
